// File: rtl/ah_lru_burst_sched.sv
// ah_lru_burst_sched: least-recently-used burst scheduler that shares one
// beat-oriented resource between NREQ requesters.
//
// Ports:
//   clk_i       clock, all state on the rising edge
//   rstn_i      asynchronous active-low reset
//   req_i       level-sensitive request vector, bit i = requester i
//   req_len_i   per-requester burst length minus one, slice i = [i*LENW +: LENW]
//   rsrc_rdy_i  resource accepts one beat this cycle
//   gnt_o       registered one-hot grant, all-zero when idle
//   gnt_vld_o   OR of gnt_o
//   gnt_id_o    binary index of the granted requester, 0 when idle
//   gnt_last_o  current beat is the final beat of the burst
module ah_lru_burst_sched #(
  parameter int unsigned NREQ = 7,
  parameter int unsigned LENW = 4,
  localparam int unsigned IdW = $clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LENW-1:0] req_len_i,
  input  logic                 rsrc_rdy_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 gnt_vld_o,
  output logic [IdW-1:0]       gnt_id_o,
  output logic                 gnt_last_o
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  // Ages form a permutation of 0..NREQ-1; larger age = waited longer.
  logic [IdW-1:0]  age_q [NREQ];
  logic [IdW-1:0]  age_d [NREQ];

  // Oldest requesting index. Ages are unique, so no tie-break is needed.
  logic           win_vld;
  logic [IdW-1:0] win_id;
  logic [IdW-1:0] win_age;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_age = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_i[i] && (!win_vld || (age_q[i] > win_age))) begin
        win_vld = 1'b1;
        win_id  = IdW'(i);
        win_age = age_q[i];
      end
    end
  end

  // Burst progress for the held winner. A dropped request aborts and wins
  // over a ready strobe in the same cycle.
  logic req_w, beat, abort, done;

  assign req_w = req_i[id_q];
  assign abort = !req_w;
  assign beat  = rsrc_rdy_i && req_w;
  assign done  = abort || (beat && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      age_d[i] = age_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d        = StBurst;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          // Length is captured once; later changes to req_len_i are ignored.
          cnt_d          = req_len_i[win_id*LENW +: LENW];
        end
      end
      StBurst: begin
        if (done) begin
          state_d = StIdle;
          gnt_d   = '0;
          id_d    = '0;
          cnt_d   = '0;
          // Everyone younger than the winner ages by one; winner becomes youngest.
          for (int unsigned j = 0; j < NREQ; j++) begin
            if (age_q[j] < age_q[id_q]) begin
              age_d[j] = age_q[j] + IdW'(1);
            end
          end
          age_d[id_q] = '0;
        end else if (beat) begin
          cnt_d = cnt_q - LENW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        age_q[i] <= IdW'(NREQ - 1 - i);
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_vld_o  = |gnt_q;
  assign gnt_id_o   = id_q;
  assign gnt_last_o = (state_q == StBurst) && (cnt_q == '0);

endmodule

// File: tb/tb_ah_lru_burst_sched.sv
// Self-checking bench for ah_lru_burst_sched: a scoreboard of expected grants
// (id, programmed length, duration, idle gap) is filled by the stimulus and
// consumed by a monitor sampling on the falling clock edge.
module tb_ah_lru_burst_sched;

  localparam int unsigned NREQ = 7;
  localparam int unsigned LENW = 4;
  localparam int unsigned IdW  = $clog2(NREQ);

  logic                 clk_i = 1'b0;
  logic                 rstn_i = 1'b0;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ*LENW-1:0] req_len_i = '0;
  logic                 rsrc_rdy_i = 1'b1;
  logic [NREQ-1:0]      gnt_o;
  logic                 gnt_vld_o;
  logic [IdW-1:0]       gnt_id_o;
  logic                 gnt_last_o;

  ah_lru_burst_sched #(
    .NREQ (NREQ),
    .LENW (LENW)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_i      (req_i),
    .req_len_i  (req_len_i),
    .rsrc_rdy_i (rsrc_rdy_i),
    .gnt_o      (gnt_o),
    .gnt_vld_o  (gnt_vld_o),
    .gnt_id_o   (gnt_id_o),
    .gnt_last_o (gnt_last_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int id;
    int len;
    int dur;
    int gap;  // required idle cycles before this grant, -1 = unchecked
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   mon_en   = 1'b0;
  bit   in_burst = 1'b0;
  int   dur_cnt  = 0;
  int   idle_cnt = 0;
  int   rem      = 0;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (gnt_vld_o) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          dur_cnt  = 0;
          if (sb_q.size() == 0) begin
            check_eq("unexpected_gnt", 32'(gnt_id_o), NREQ);
            cur = '{int'(gnt_id_o), 0, 0, -1};
          end else begin
            cur = sb_q.pop_front();
            check_eq("gnt_id", 32'(gnt_id_o), cur.id);
            check_eq("gnt_onehot", 32'(gnt_o), 32'(1) << cur.id);
            if (cur.gap >= 0) check_eq("idle_gap", idle_cnt, cur.gap);
          end
          rem = cur.len;
        end
        dur_cnt++;
        check_eq("gnt_id_hold", 32'(gnt_id_o), cur.id);
        check_eq("gnt_last", 32'(gnt_last_o), (rem == 0) ? 1 : 0);
        if (rsrc_rdy_i && req_i[cur.id] && rem > 0) rem--;
      end else begin
        if (in_burst) begin
          in_burst = 1'b0;
          check_eq("gnt_dur", dur_cnt, cur.dur);
          idle_cnt = 0;
        end
        idle_cnt++;
        check_eq("idle_id", 32'(gnt_id_o), 0);
        check_eq("idle_last", 32'(gnt_last_o), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_len(input int id, input int len);
    req_len_i[id*LENW +: LENW] = LENW'(len);
  endtask

  task automatic push(input int id, input int len, input int dur, input int gap);
    sb_q.push_back('{id, len, dur, gap});
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    in_burst   = 1'b0;
    idle_cnt   = 0;
    sb_q.delete();
    rstn_i     = 1'b0;
    req_i      = '0;
    req_len_i  = '0;
    rsrc_rdy_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rstn_i = 1'b1;
    tick(1);
    mon_en = 1'b1;
  endtask

  // Wait until every expected grant has been seen and the bus is idle, then
  // withdraw all requests before the next arbitration edge.
  task automatic drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!((sb_q.size() == 0) && !gnt_vld_o) && n < budget);
    check_eq("drain_timeout", (n < budget) ? 1 : 0, 1);
    req_i = '0;
    tick(3);
    check_eq("drain_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int rst_age [NREQ];
  int t2_age  [NREQ] = '{6, 5, 4, 0, 3, 2, 1};
  int t2_ord  [7]    = '{0, 1, 2, 4, 5, 6, 3};
  bit t3_rdy  [7]    = '{1, 0, 1, 0, 1, 0, 1};

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_gnt", 32'(gnt_o), 0);
    check_eq("rst_vld", 32'(gnt_vld_o), 0);
    check_eq("rst_id", 32'(gnt_id_o), 0);
    check_eq("rst_last", 32'(gnt_last_o), 0);
    for (int i = 0; i < NREQ; i++) begin
      rst_age[i] = NREQ - 1 - i;
      check_eq("rst_age", 32'(dut.age_q[i]), rst_age[i]);
    end

    // All requesting, single-beat bursts: round robin by age
    for (int i = 0; i < 8; i++) push(i % NREQ, 0, 1, (i == 0) ? -1 : 1);
    req_i = 7'h7F;
    drain(100);

    // Requester 3 served first becomes youngest
    do_reset();
    push(3, 0, 1, -1);
    req_i = 7'h08;
    drain(50);
    for (int i = 0; i < 7; i++) push(t2_ord[i], 0, 1, (i == 0) ? -1 : 1);
    req_i = 7'h7F;
    drain(100);
    for (int i = 0; i < NREQ; i++) check_eq("t2_age", 32'(dut.age_q[i]), t2_age[i]);

    // Stalled 4-beat burst
    do_reset();
    set_len(2, 3);
    push(2, 3, 7, -1);
    req_i = 7'h04;
    tick(1);
    for (int k = 0; k < 7; k++) begin
      rsrc_rdy_i = t3_rdy[k];
      tick(1);
    end
    rsrc_rdy_i = 1'b1;
    drain(50);

    // Abort after two beats, then 0 wins over freshly served 5
    do_reset();
    set_len(5, 7);
    push(5, 7, 3, -1);
    push(0, 0, 1, 1);
    push(5, 7, 8, 1);
    req_i = 7'h20;
    tick(3);
    req_i = 7'h00;
    tick(1);
    req_i = 7'h21;
    drain(100);

    // Asynchronous reset mid-burst
    do_reset();
    mon_en = 1'b0;
    set_len(1, 5);
    req_i = 7'h02;
    tick(1);
    check_eq("t5_gnt", 32'(gnt_o), 32'h02);
    tick(3);
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("t5_async_gnt", 32'(gnt_o), 0);
    check_eq("t5_async_vld", 32'(gnt_vld_o), 0);
    check_eq("t5_async_id", 32'(gnt_id_o), 0);
    check_eq("t5_async_last", 32'(gnt_last_o), 0);
    for (int i = 0; i < NREQ; i++) check_eq("t5_age", 32'(dut.age_q[i]), rst_age[i]);
    #2;
    rstn_i    = 1'b1;
    req_len_i = '0;
    in_burst  = 1'b0;
    idle_cnt  = 0;
    push(0, 0, 1, -1);
    req_i  = 7'h7F;
    mon_en = 1'b1;
    drain(50);

    // Late request and length change during a burst are ignored
    do_reset();
    set_len(4, 2);
    push(4, 2, 3, -1);
    push(6, 0, 1, 1);
    req_i = 7'h10;
    tick(1);
    req_i = 7'h50;
    set_len(4, 7);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
